hack_loader: RTL and testbench
==============================

# hack_loader

Boot loader sitting upstream of the HACK CPU. It receives a program image as a byte stream (valid/ready), assembles big-endian 16-bit instruction words, and writes them into the instruction memory that drives the CPU `instruction` input. The CPU's active-high `rst` is held asserted until a complete, checksum-verified image is loaded. A failed load leaves the CPU held in reset.

## Interface
Parameters:
- `DEPTH`, default 32768: number of instruction-memory words; the writable address range is 0..DEPTH-1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `reload`  in  1  synchronous pulse; restarts the load from any state.
- `rx_data`  in  8  incoming image byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  15  write address (word index).
- `imem_wdata`  out  16  write data.
- `cpu_rst`  out  1  active-high reset to the CPU.
- `busy`  out  1  load in progress.
- `done`  out  1  image verified; CPU running.
- `error`  out  1  load failed (overflow or checksum mismatch).
- `words_loaded`  out  16  count of data words received in the current load.

## Operation
- Image format: LEN_HI, LEN_LO, then N data words as hi/lo byte pairs, then SUM_HI, SUM_LO.
  - N = {LEN_HI, LEN_LO}, range 0..65535.
  - SUM = sum of all N data words, mod 2^16.
- A byte is accepted when `rx_valid && rx_ready`.
  - `rx_ready` = 1 in states LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO.
  - `rx_ready` = 0 in RUN and FAIL.
- State transitions:
  - LEN_HI → LEN_LO on acceptance.
  - LEN_LO → DATA_HI, or → SUM_HI if N = 0.
  - DATA_HI → DATA_LO.
  - DATA_LO → DATA_HI, or → SUM_HI after the Nth word.
  - SUM_HI → SUM_LO.
  - SUM_LO → RUN if the received sum equals the accumulator and no overflow occurred; otherwise → FAIL.
  - RUN and FAIL are terminal until `reload` or `rst`.
- `reload` from any state, including mid-image:
  - go to LEN_HI;
  - clear the accumulator, `words_loaded` and `error`;
  - assert `cpu_rst`;
  - abandon any partial word.
  - If `reload` and a byte acceptance coincide, `reload` wins and the byte is dropped.
- Data word handling on DATA_LO acceptance:
  - word = {held hi byte, `rx_data`};
  - accumulator += word, mod 2^16;
  - `words_loaded` += 1.
  - If the word index < DEPTH, issue a write. Otherwise drop the write, set a sticky overflow flag and keep consuming bytes to the end of the image.
- Output states:
  - `cpu_rst` = 1 in every state except RUN.
  - `busy` = 1 in the LEN/DATA/SUM states.
  - `done` = 1 in RUN.
  - `error` = 1 in FAIL.
- No bus stall: an idle `rx_valid` simply holds the current state indefinitely.

## Timing
- Reset values (`rst` low):
  - state = LEN_HI
  - `rx_ready` = 1 after release
  - `imem_we` = 0
  - `imem_addr` = 0
  - `imem_wdata` = 0
  - `cpu_rst` = 1
  - `busy` = 1
  - `done` = 0
  - `error` = 0
  - `words_loaded` = 0
- All outputs are registered.
- `imem_we` is a 1-cycle pulse in the cycle after the DATA_LO acceptance; `imem_addr` and `imem_wdata` are valid in that same cycle.
- Throughput: one byte per cycle; a word is written every 2 cycles at full rate.
- `cpu_rst` falls, and `done` rises, in the cycle after SUM_LO acceptance. This is always at least one cycle after the last `imem_we`.
- On FAIL, `error` rises in the cycle after SUM_LO acceptance; `cpu_rst` stays 1.
- `reload` takes effect on the next edge: `cpu_rst` = 1 and state = LEN_HI in the following cycle.
- Asserting `rst` mid-image discards all progress immediately. Memory contents are not cleared.

## Structure
- Shared package/header holds:
  - the state encoding (LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN, FAIL);
  - the 8-bit byte and 16-bit word width constants;
  - the 15-bit address width shared with the CPU `pc`/`addressM`.
- One sub-module is natural: `loader_sum16`, holding the mod-2^16 accumulator with clear and add-enable.
- The FSM, word assembly and write-port logic stay in `hack_loader`.

## Test plan
- Basic load: reset, then bytes 00 02 12 34 ED CC 00 00.
  - Expect writes [0]=0x1234 and [1]=0xEDCC.
  - `cpu_rst` falls one cycle after the last byte; `done` = 1; `words_loaded` = 2.
- Bad checksum: bytes 00 01 AB CD AB CE.
  - Expect one write [0]=0xABCD, then `error` = 1 and `cpu_rst` stays 1.
  - `rx_ready` = 0 afterwards.
- Empty image: bytes 00 00 00 00.
  - Expect no `imem_we`; `done` = 1 after 4 accepted bytes.
- Overflow: set `DEPTH` = 4 and send N = 5 with a correct sum.
  - Expect 4 writes, the 5th word consumed but not written, then FAIL with `error` = 1.
- Reload mid-image and backpressure:
  - Pulse `reload` after LEN and one hi byte; expect state LEN_HI, `words_loaded` = 0, `cpu_rst` = 1.
  - Then run the basic load with `rx_valid` toggling every other cycle; expect identical writes and completion.
  - Repeat with `rst` asserted mid-image: `cpu_rst` = 1 and all outputs at their reset values.

Source files
------------

// File: rtl/hack_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader_pkg
// Brief    : Shared widths and loader state encoding for the HACK boot loader.
// Revision : 1.0
// ============================================================================
package hack_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;  // matches the CPU pc/addressM width

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_SUM_HI  = 3'd4,
        S_SUM_LO  = 3'd5,
        S_RUN     = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hack_loader_sum16.sv
`default_nettype none
// ============================================================================
// Module   : loader_sum16
// Brief    : Mod-2^16 running sum of image data words, with clear and add-enable.
// Revision : 1.0
// ============================================================================
module loader_sum16
    import hack_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [WORD_W-1:0] add_val,
    output logic [WORD_W-1:0] sum
);

    logic [WORD_W-1:0] sum_q;
    logic [WORD_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + add_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/hack_loader.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader
// Brief    : Byte-stream boot loader; writes a checksummed image into HACK imem.
// Revision : 1.0
// ============================================================================
module hack_loader
    import hack_loader_pkg::*;
#(
    parameter int DEPTH = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] words_loaded
);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] len_q, len_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic              add_en;
    logic [WORD_W-1:0] rx_word;
    logic [WORD_W-1:0] acc;

    assign accept  = rx_valid && rx_ready_q;
    assign rx_word = {hi_q, rx_data};

    loader_sum16 u_sum (
        .clk     (clk),
        .rst     (rst),
        .clr     (reload),
        .add_en  (add_en),
        .add_val (rx_word),
        .sum     (acc)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        add_en  = 1'b0;

        // reload outranks a coincident byte, which is simply dropped
        if (reload) begin
            state_d = S_LEN_HI;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            case (state_q)
                S_LEN_HI: begin
                    hi_d    = rx_data;
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d   = rx_word;
                    state_d = (rx_word == '0) ? S_SUM_HI : S_DATA_HI;
                end
                S_DATA_HI: begin
                    hi_d    = rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    add_en = 1'b1;
                    cnt_d  = cnt_q + 16'd1;
                    if ({16'd0, cnt_q} < 32'(DEPTH)) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = rx_word;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    state_d = (cnt_d == len_q) ? S_SUM_HI : S_DATA_HI;
                end
                S_SUM_HI: begin
                    hi_d    = rx_data;
                    state_d = S_SUM_LO;
                end
                S_SUM_LO: begin
                    state_d = (rx_word == acc && !ovf_q) ? S_RUN : S_FAIL;
                end
                default: ;
            endcase
        end

        // Status outputs are registered copies of the next-state decode
        rx_ready_d = (state_d != S_RUN) && (state_d != S_FAIL);
        busy_d     = rx_ready_d;
        done_d     = (state_d == S_RUN);
        error_d    = (state_d == S_FAIL);
        cpu_rst_d  = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LEN_HI;
            hi_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_loader
// Brief    : Scoreboard bench for hack_loader with a queue-based image model.
// Revision : 1.0
// ============================================================================
module tb_hack_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reload;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [14:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    hack_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .reload       (reload),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct packed {
        logic        ok;
        logic [15:0] n;
    } res_t;

    int          errors = 0;
    int          checks = 0;
    logic [30:0] wq[$];   // expected writes {addr, data}
    res_t        rq[$];   // expected load outcomes
    logic [15:0] img[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or finishes a load
    logic prev_busy = 1'b1;
    always @(negedge clk) begin
        logic [30:0] w;
        res_t        r;
        if (imem_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_write", {1'b0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                check("write", {1'b0, imem_addr, imem_wdata}, {1'b0, w});
            end
        end
        if (prev_busy && busy === 1'b0) begin
            if (rq.size() == 0) begin
                check("unexpected_end", {31'd0, done}, 32'hFFFF_FFFF);
            end else begin
                r = rq.pop_front();
                check("end_done", {31'd0, done}, {31'd0, r.ok});
                check("end_error", {31'd0, error}, {31'd0, !r.ok});
                check("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, !r.ok});
                check("end_words", {16'd0, words_loaded}, {16'd0, r.n});
                check("end_rx_ready", {31'd0, rx_ready}, 32'd0);
            end
        end
        prev_busy = busy;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Model: sends img, pushing the writes and outcome the image should produce
    task automatic run_image(input bit use_sum, input logic [15:0] sum_in, input int maxgap);
        int          n;
        logic [15:0] true_sum;
        logic [15:0] sent_sum;
        n = img.size();
        true_sum = 16'd0;
        foreach (img[i]) true_sum = 16'((int'(true_sum) + int'(img[i])) % 65536);
        sent_sum = use_sum ? sum_in : true_sum;
        send_byte(8'(n >> 8), $urandom_range(0, maxgap));
        send_byte(8'(n), $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            send_byte(img[i][15:8], $urandom_range(0, maxgap));
            if (i < DEPTH) wq.push_back({15'(i), img[i]});
            send_byte(img[i][7:0], $urandom_range(0, maxgap));
        end
        rq.push_back('{ok: (sent_sum == true_sum) && (n <= DEPTH), n: 16'(n)});
        send_byte(sent_sum[15:8], $urandom_range(0, maxgap));
        send_byte(sent_sum[7:0], $urandom_range(0, maxgap));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("reload_words", {16'd0, words_loaded}, 32'd0);
        check("reload_ready", {31'd0, rx_ready}, 32'd1);
        check("reload_error", {31'd0, error}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_addr"}, {17'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        reload   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

        // Basic load: 00 02 12 34 ED CC 00 00
        img = '{16'h1234, 16'hEDCC};
        run_image(1'b0, 16'h0, 0);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("basic_words", {16'd0, words_loaded}, 32'd2);

        // Bad checksum: 00 01 AB CD AB CE
        pulse_reload();
        img = '{16'hABCD};
        run_image(1'b1, 16'hABCE, 0);
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Empty image
        pulse_reload();
        img.delete();
        run_image(1'b0, 16'h0, 0);
        check("empty_done", {31'd0, done}, 32'd1);

        // Overflow: five words into a four-word memory
        pulse_reload();
        img = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        run_image(1'b0, 16'h0, 0);
        check("ovf_error", {31'd0, error}, 32'd1);

        // Reload after LEN and one hi byte, then toggled-valid basic load
        pulse_reload();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        pulse_reload();
        img = '{16'h1234, 16'hEDCC};
        run_image(1'b0, 16'h0, 1);
        check("toggle_done", {31'd0, done}, 32'd1);

        // Asynchronous reset mid-image
        pulse_reload();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        wq.push_back({15'd0, 16'h1234});
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hED, 0);
        rst = 1'b0;
        #2;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        img = '{16'h1234, 16'hEDCC};
        run_image(1'b0, 16'h0, 0);
        check("after_reset_done", {31'd0, done}, 32'd1);

        // Randomized images, including overflow and corrupted sums
        for (int t = 0; t < 25; t++) begin
            int n;
            pulse_reload();
            img.delete();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) img.push_back(16'($urandom));
            if ($urandom_range(0, 3) == 0)
                run_image(1'b1, 16'($urandom), $urandom_range(0, 2));
            else
                run_image(1'b0, 16'h0, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        #1;
        check("writes_drained", wq.size(), 32'd0);
        check("results_drained", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
